data_mem_responder: RTL and testbench

Memory-side responder for the datapath's load/store interface. It accepts one request at a time over a valid/ready handshake. It services byte, halfword and word loads and stores against a byte-addressed, big-endian 1 KiB array after a programmable number of wait states, then returns the result over a second valid/ready handshake. It replaces the zero-latency data memory when the core is exercised against realistic multi-cycle memory.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 58 +++++
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the multi-cycle data memory responder: access sizes,
// FSM states and wait-counter width.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Number of bytes touched by an access; illegal sizes report one byte so the
  // range check stays well defined (they are flagged as errors separately).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane placement: lane 0 is the lowest address of the aligned
// word. Produces store lanes/enables and the extended load value.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [1:0]      offset,
  input  logic [31:0]     wdata,
  input  logic [3:0][7:0] raw,
  output logic [3:0][7:0] lane_wdata,
  output logic [3:0]      lane_be,
  output logic [31:0]     load_data
);

  logic [7:0]  sel8_s;
  logic [15:0] sel16_s;

  // Lane steering for stores and load assembly/extension
  always_comb begin
    lane_wdata = 32'h0000_0000;
    lane_be    = 4'b0000;
    load_data  = 32'h0000_0000;
    sel8_s     = raw[offset];
    sel16_s    = offset[1] ? {raw[2], raw[3]} : {raw[0], raw[1]};
    case (size)
      SIZE_BYTE: begin
        lane_be[offset]    = 1'b1;
        lane_wdata[offset] = wdata[7:0];
        load_data = uns ? {24'h00_0000, sel8_s} : {{24{sel8_s[7]}}, sel8_s};
      end
      SIZE_HALF: begin
        if (offset[1]) begin
          lane_be       = 4'b1100;
          lane_wdata[2] = wdata[15:8];
          lane_wdata[3] = wdata[7:0];
        end else begin
          lane_be       = 4'b0011;
          lane_wdata[0] = wdata[15:8];
          lane_wdata[1] = wdata[7:0];
        end
        load_data = uns ? {16'h0000, sel16_s} : {{16{sel16_s[15]}}, sel16_s};
      end
      SIZE_WORD: begin
        lane_be       = 4'b1111;
        lane_wdata[0] = wdata[31:24];
        lane_wdata[1] = wdata[23:16];
        lane_wdata[2] = wdata[15:8];
        lane_wdata[3] = wdata[7:0];
        load_data     = {raw[0], raw[1], raw[2], raw[3]};
      end
      default: begin
        lane_be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder over a byte-addressed big-endian array,
// with request and response valid/ready handshakes.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             wr_r;
  logic             uns_r;
  logic [31:0]      addr_r;
  logic [1:0]       size_r;
  logic [31:0]      wdata_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_rdata_r;
  logic             rsp_error_r;
  logic [7:0]       mem_r [DEPTH_BYTES];

  logic             access_s;
  logic             size_err_s;
  logic             range_err_s;
  logic             err_s;
  logic [32:0]      last_s;
  logic [AW-1:0]    base_s;
  logic [3:0][7:0]  raw_s;
  logic [3:0][7:0]  lane_wdata_s;
  logic [3:0]       lane_be_s;
  logic [31:0]      load_s;

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_error = rsp_error_r;

  // WAIT lasts WAIT_STATES+1 cycles, leaving WAIT_STATES idle cycles between
  // the accepting edge and the access edge.
  assign access_s = (state_r == WAIT) && (cnt_r == CNT_W'(WAIT_STATES));
  assign base_s   = addr_r[AW-1:0] & ~AW'(3);

  // Alignment, size and full-width range checks on the latched request
  always_comb begin
    last_s = {1'b0, addr_r} + 33'(size_bytes(size_r)) - 33'd1;
    case (size_r)
      SIZE_BYTE: size_err_s = 1'b0;
      SIZE_HALF: size_err_s = addr_r[0];
      SIZE_WORD: size_err_s = |addr_r[1:0];
      default:   size_err_s = 1'b1;
    endcase
    if (last_s >= 33'(DEPTH_BYTES)) begin
      range_err_s = 1'b1;
    end else begin
      range_err_s = 1'b0;
    end
    err_s = size_err_s | range_err_s;
  end

  // Fetch the four bytes of the aligned word containing the address
  always_comb begin
    raw_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      raw_s[k] = mem_r[base_s | AW'(k)];
    end
  end

  mem_lane_align u_align (
    .size       (size_r),
    .uns        (uns_r),
    .offset     (addr_r[1:0]),
    .wdata      (wdata_r),
    .raw        (raw_s),
    .lane_wdata (lane_wdata_s),
    .lane_be    (lane_be_s),
    .load_data  (load_s)
  );

  // Byte array write port; contents survive rst by design
  always_ff @(posedge clk) begin
    if (!rst && access_s && wr_r && !err_s) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_be_s[k]) begin
          mem_r[base_s | AW'(k)] <= lane_wdata_s[k];
        end
      end
    end
  end

  // Control FSM with request latch and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      wr_r        <= 1'b0;
      uns_r       <= 1'b0;
      addr_r      <= 32'h0000_0000;
      size_r      <= SIZE_BYTE;
      wdata_r     <= 32'h0000_0000;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            wr_r        <= req_write;
            uns_r       <= req_unsigned;
            addr_r      <= req_addr;
            size_r      <= req_size;
            wdata_r     <= req_wdata;
            cnt_r       <= '0;
            req_ready_r <= 1'b0;
            state_r     <= WAIT;
          end
        end
        WAIT: begin
          if (access_s) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_error_r <= err_s;
            rsp_rdata_r <= (err_s || wr_r) ? 32'h0000_0000 : load_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_error_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, backpressure,
// reset corner cases, randomized traffic and a zero-wait-state throughput run.
module tb_data_mem_responder;

  localparam int WS = 2;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        req_valid0, req_ready0, rsp_valid0, rsp_error0;
  logic [31:0] rsp_rdata0;

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_mem [1024];
  vec_t vecs[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
    .rsp_ready(1'b1), .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: byte-at-a-time big-endian access on a plain array.
  function automatic void ref_access(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                                     input bit uns, input logic [31:0] wd,
                                     output logic [31:0] rd, output bit er);
    int n;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || ((a % 32'(n)) != 32'd0) || (({32'h0, a} + 64'(n)) > 64'd1024);
    rd = 32'h0;
    if (!er) begin
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[int'(a) + i]);
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
      end
    end
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                              input bit uns, input logic [31:0] wd,
                              input logic [31:0] erd, input bit eer);
    vec_t v;
    v.wr = wr; v.addr = a; v.size = sz; v.uns = uns; v.wdata = wd;
    v.exp_rd = erd; v.exp_er = eer;
    return v;
  endfunction

  // One full transaction on the WS=2 instance, with optional backpressure.
  task automatic do_req(input string nm, input bit wr, input logic [31:0] a,
                        input logic [1:0] sz, input bit uns, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_er,
                        input int hold, input bit poke);
    int k;
    logic [31:0] rd0;
    logic er0;
    @(negedge clk);
    req_write = wr; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    check({nm, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, 32'(k), 32'(WS + 1));
    check({nm, " rdata"}, rsp_rdata, exp_rd);
    check({nm, " error"}, 32'(rsp_error), 32'(exp_er));
    rd0 = rsp_rdata;
    er0 = rsp_error;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0010;
        req_size  = 2'b10;
        req_wdata = 32'h0BAD_0BAD;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check({nm, " hold"}, {rsp_rdata}, rd0);
      check({nm, " hold flags"}, {29'h0, rsp_valid, rsp_error, req_ready}, {29'h0, 1'b1, er0, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, " after rsp"}, {30'h0, req_ready, rsp_valid}, {30'h0, 2'b10});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit er;
    logic [1:0] sz;
    logic [31:0] a;
    int cyc, idx, t;
    int acc[4];
    logic [31:0] rsps[$];
    logic [31:0] exp0[4];

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 32'h0; req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {rsp_rdata[30:0], rsp_error}, 32'h0);
    check("reset flags", {28'h0, req_ready, rsp_valid, req_ready0, rsp_valid0}, {28'h0, 4'b1010});
    rst = 1'b0;

    vecs.push_back(mk(1, 32'h010, 2'd2, 0, 32'hDEAD_BEEF, 32'h0, 0));
    vecs.push_back(mk(0, 32'h010, 2'd2, 0, 32'h0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 32'h011, 2'd0, 0, 32'h0, 32'hFFFF_FFAD, 0));
    vecs.push_back(mk(0, 32'h011, 2'd0, 1, 32'h0, 32'h0000_00AD, 0));
    vecs.push_back(mk(0, 32'h012, 2'd1, 0, 32'h0, 32'hFFFF_BEEF, 0));
    vecs.push_back(mk(0, 32'h012, 2'd1, 1, 32'h0, 32'h0000_BEEF, 0));
    vecs.push_back(mk(1, 32'h011, 2'd1, 0, 32'h0000_1234, 32'h0, 1));
    vecs.push_back(mk(0, 32'h002, 2'd2, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 32'h3FE, 2'd2, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 32'h010, 2'd3, 0, 32'h5555_5555, 32'h0, 1));
    vecs.push_back(mk(0, 32'h010, 2'd0, 1, 32'h0, 32'h0000_00DE, 0));
    vecs.push_back(mk(0, 32'h011, 2'd0, 1, 32'h0, 32'h0000_00AD, 0));
    vecs.push_back(mk(0, 32'h012, 2'd0, 1, 32'h0, 32'h0000_00BE, 0));
    vecs.push_back(mk(0, 32'h013, 2'd0, 1, 32'h0, 32'h0000_00EF, 0));
    vecs.push_back(mk(0, 32'h010, 2'd2, 0, 32'h0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 32'h3FC, 2'd2, 0, 32'h8000_0001, 32'h0, 0));
    vecs.push_back(mk(0, 32'h3FC, 2'd2, 0, 32'h0, 32'h8000_0001, 0));
    vecs.push_back(mk(0, 32'h3FF, 2'd0, 0, 32'h0, 32'h0000_0001, 0));
    vecs.push_back(mk(0, 32'h3FC, 2'd0, 0, 32'h0, 32'hFFFF_FF80, 0));
    vecs.push_back(mk(0, 32'h3FE, 2'd1, 1, 32'h0, 32'h0000_0001, 0));
    vecs.push_back(mk(0, 32'h400, 2'd0, 1, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 32'hFFFF_FFFF, 2'd0, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 32'h0001_0010, 2'd2, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 32'h3FE, 2'd1, 0, 32'hA5A5_C3C3, 32'h0, 0));
    vecs.push_back(mk(0, 32'h3FE, 2'd1, 0, 32'h0, 32'hFFFF_C3C3, 0));

    foreach (vecs[i]) begin
      ref_access(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, rd, er);
      do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns,
             vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_er, i % 3, 1'b0);
    end

    do_req("backpressure", 0, 32'h010, 2'd2, 0, 32'h0, 32'hDEAD_BEEF, 0, 5, 1'b1);
    do_req("after poke", 0, 32'h010, 2'd2, 0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);

    // Reset while a store waits: the store must be dropped.
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h020; req_size = 2'd2; req_wdata = 32'h1122_3344;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst wait flags", {30'h0, req_ready, rsp_valid}, {30'h0, 2'b10});
    do_req("rst wait load", 0, 32'h020, 2'd2, 0, 32'h0, 32'h0000_0000, 0, 0, 1'b0);

    // Reset while a store's response is pending: the store stays.
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h030; req_size = 2'd2; req_wdata = 32'h5566_7788;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    check("rst resp reached", 32'(rsp_valid), 32'd1);
    ref_access(1, 32'h030, 2'd2, 0, 32'h5566_7788, rd, er);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst resp flags", {30'h0, req_ready, rsp_valid}, {30'h0, 2'b10});
    do_req("rst resp load", 0, 32'h030, 2'd2, 0, 32'h0, 32'h5566_7788, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1, 2:    a = 32'($urandom_range(32'h3F0, 32'h40F));
        default: a = 32'($urandom_range(0, 32'h3F));
      endcase
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      begin
        bit wr_b, uns_b;
        logic [31:0] wd;
        wr_b = 1'($urandom_range(0, 1));
        uns_b = 1'($urandom_range(0, 1));
        wd = $urandom;
        ref_access(wr_b, a, sz, uns_b, wd, rd, er);
        do_req($sformatf("rnd%0d", n), wr_b, a, sz, uns_b, wd, rd, er,
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    // Zero wait states, back-to-back requests, consumer always ready.
    exp0[0] = 32'h0; exp0[1] = 32'hCAFE_F00D; exp0[2] = 32'h0; exp0[3] = 32'hFFFF_8001;
    idx = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (rsp_valid0) rsps.push_back(rsp_rdata0);
      if (idx < 4) begin
        case (idx)
          0: begin req_write = 1; req_addr = 32'h040; req_size = 2'd2; req_wdata = 32'hCAFE_F00D; end
          1: begin req_write = 0; req_addr = 32'h040; req_size = 2'd2; req_wdata = 32'h0; end
          2: begin req_write = 1; req_addr = 32'h046; req_size = 2'd1; req_wdata = 32'h0000_8001; end
          default: begin req_write = 0; req_addr = 32'h046; req_size = 2'd1; req_wdata = 32'h0; end
        endcase
        req_unsigned = 1'b0;
        req_valid0 = 1'b1;
        if (req_ready0) begin
          acc[idx] = cyc;
          idx++;
        end
      end else begin
        req_valid0 = 1'b0;
      end
      @(posedge clk);
    end
    req_valid0 = 1'b0;
    check("w0 accepted", 32'(idx), 32'd4);
    for (int i = 1; i < 4; i++) check($sformatf("w0 gap%0d", i), 32'(acc[i] - acc[i-1]), 32'd3);
    check("w0 responses", 32'(rsps.size()), 32'd4);
    for (int i = 0; i < 4 && i < rsps.size(); i++) check($sformatf("w0 rdata%0d", i), rsps[i], exp0[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
